// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
//   Shared constants for the adder family (ripple baseline and the faster
//   variants that are compared against it).
//   Contents:
//     ADDER_WIDTH  default operand/sum width
//     S_RST_VAL    value loaded into the registered sum on reset
//     CO_RST_VAL   value loaded into the registered carry out on reset
// ---------------------------------------------------------------------------
package adder_pkg;

  localparam int ADDER_WIDTH = 16;

  localparam logic [ADDER_WIDTH-1:0] S_RST_VAL  = '0;
  localparam logic                   CO_RST_VAL = 1'b0;

endpackage : adder_pkg

// File: rtl/ripple_adder_16bit_full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//   One-bit full adder cell, purely combinational. Chained by the ripple
//   adder top level to form the carry chain.
//   Ports:
//     a, b  input   operand bits
//     cin   input   carry in
//     s     output  sum bit   = a ^ b ^ cin
//     cout  output  carry out = majority(a, b, cin)
// ---------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/ripple_adder_16bit.sv
// ---------------------------------------------------------------------------
// ripple_adder_16bit
//   Unsigned adder {Co,S} = X + Y + Ci built as a strict bit-to-bit ripple of
//   full_adder cells, followed by a single output register (1-cycle latency,
//   one new operation accepted every cycle, no handshake).
//   Ports:
//     clk  input          rising-edge clock
//     rst  input          synchronous active-high reset; clears S and Co and
//                         discards the operation sampled on that edge
//     X    input  WIDTH   addend A
//     Y    input  WIDTH   addend B
//     Ci   input          carry into bit 0
//     S    output WIDTH   registered sum
//     Co   output         registered carry out of the top bit
// ---------------------------------------------------------------------------
module ripple_adder_16bit
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Ci,
  output logic [WIDTH-1:0] S,
  output logic             Co
);

  // c[i] is the carry into bit i; c[WIDTH] is the carry out of the chain.
  // The critical path runs through every cell from c[0] to c[WIDTH].
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_d;
  logic             co_d;
  logic [WIDTH-1:0] S_q;
  logic             Co_q;

  assign c[0] = Ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder u_fa (
      .a    (X[i]),
      .b    (Y[i]),
      .cin  (c[i]),
      .s    (s_d[i]),
      .cout (c[i+1])
    );
  end

  assign co_d = c[WIDTH];

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      S_q  <= WIDTH'(S_RST_VAL);
      Co_q <= CO_RST_VAL;
    end else begin
      S_q  <= s_d;
      Co_q <= co_d;
    end
  end

  assign S  = S_q;
  assign Co = Co_q;

endmodule : ripple_adder_16bit

// File: tb/tb_ripple_adder_16bit.sv
module tb_ripple_adder_16bit;

  logic        clk;
  logic        rst;
  logic [15:0] X;
  logic [15:0] Y;
  logic        Ci;
  logic [15:0] S;
  logic        Co;

  int errors = 0;
  int checks = 0;
  bit drv_done = 1'b0;

  typedef struct {
    string       name;
    logic [15:0] x;
    logic [15:0] y;
    logic        ci;
    logic        r;
    logic [15:0] es;
    logic        eco;
  } item_t;

  item_t sb[$];

  ripple_adder_16bit dut (
    .clk (clk),
    .rst (rst),
    .X   (X),
    .Y   (Y),
    .Ci  (Ci),
    .S   (S),
    .Co  (Co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation ahead of the next rising edge and record the
  // hand-computed response expected right after that edge.
  task automatic apply(input string name, input logic [15:0] x, input logic [15:0] y,
                       input logic ci, input logic r,
                       input logic [15:0] es, input logic eco);
    item_t it;
    @(negedge clk);
    X   = x;
    Y   = y;
    Ci  = ci;
    rst = r;
    it.name = name; it.x = x; it.y = y; it.ci = ci; it.r = r;
    it.es = es; it.eco = eco;
    sb.push_back(it);
  endtask

  // Monitor: every rising edge presents a result; compare against the
  // directed expectation and against a behavioural X+Y+Ci model.
  initial begin
    item_t       it;
    logic [16:0] model;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        checks++;
        if (S !== it.es || Co !== it.eco) begin
          errors++;
          $display("FAIL %s: got S=%h Co=%b, expected S=%h Co=%b",
                   it.name, S, Co, it.es, it.eco);
        end
        model = it.r ? 17'd0 : ({1'b0, it.x} + {1'b0, it.y} + {16'd0, it.ci});
        checks++;
        if ({Co, S} !== model) begin
          errors++;
          $display("FAIL %s_model: got {Co,S}=%h, model {Co,S}=%h (x=%h y=%h ci=%b rst=%b)",
                   it.name, {Co, S}, model, it.x, it.y, it.ci, it.r);
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst = 1'b1;
    X   = 16'h0;
    Y   = 16'h0;
    Ci  = 1'b0;

    apply("reset0", 16'h1234, 16'h1111, 1'b0, 1'b1, 16'h0000, 1'b0);
    apply("reset1", 16'h1234, 16'h1111, 1'b1, 1'b1, 16'h0000, 1'b0);

    apply("small_add",     16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);
    apply("small_add_ci",  16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0);
    apply("ci_only",       16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0);
    apply("carry_msb",     16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);
    apply("wrap_ci",       16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    apply("full_ripple",   16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1);
    apply("alt_bits",      16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0);
    apply("alt_bits_ci",   16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1);
    apply("mixed",         16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0);
    apply("zero",          16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);

    for (int n = 1; n <= 5000; n++) begin
      if (n == 2500)
        apply("sweep_rst", 16'(n), 16'(n), 1'b0, 1'b1, 16'h0000, 1'b0);
      else
        apply("sweep", 16'(n), 16'(n), 1'b0, 1'b0, 16'(2 * n), 1'b0);
    end

    @(negedge clk);
    drv_done = 1'b1;
  end

  // Wrap-up: let the monitor drain, then confirm nothing was left unchecked.
  initial begin
    wait (drv_done);
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still pending, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog bounding the whole run.
  initial begin
    #200000;
    $display("FAIL timeout: run exceeded 200000 time units, expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_ripple_adder_16bit
